// File: rtl/tank_motion_ctrl.sv
// Per-player tank controller: frame-paced grid movement plus a fire req/ack scheduler with cooldown.
// Build option: define TANK_WRAP_EN to wrap at map edges instead of clamping.
module tank_motion_ctrl #(
    parameter int MAP_W         = 40,
    parameter int MAP_H         = 30,
    parameter int INIT_X        = 32,
    parameter int INIT_Y        = 2,
    parameter int INIT_DIR      = 0,
    parameter int MOVE_PERIOD   = 4,
    parameter int FIRE_COOLDOWN = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_tick,
    input  logic       i_enable,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    input  logic       i_fire_ack,
    output logic [5:0] o_tank_x,
    output logic [5:0] o_tank_y,
    output logic [1:0] o_tank_dir,
    output logic       o_fire_req,
    output logic [5:0] o_fire_x,
    output logic [5:0] o_fire_y,
    output logic [1:0] o_fire_dir,
    output logic       o_cooldown
);
    localparam int MCW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int CCW = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam logic [MCW-1:0] MCNT_LAST = MCW'(MOVE_PERIOD - 1);
    localparam logic [CCW-1:0] COOL_INIT = CCW'(FIRE_COOLDOWN - 1);
    localparam logic [5:0]     X_MAX     = 6'(MAP_W - 1);
    localparam logic [5:0]     Y_MAX     = 6'(MAP_H - 1);
`ifdef TANK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_COOL} fire_state_t;

    fire_state_t    state, state_nxt;
    logic [MCW-1:0] mcnt;
    logic [CCW-1:0] cool_cnt;
    logic           tick_en, move_tick;
    logic           want_vld;
    logic [1:0]     want_dir;
    logic [5:0]     nx, ny;
    logic           snap_ld, cool_ld, cool_dec;

    assign tick_en   = i_frame_tick & i_enable;
    assign move_tick = tick_en && (mcnt == MCNT_LAST);

    always_comb begin
        want_vld = 1'b1;
        want_dir = o_tank_dir;
        if      (i_up)    want_dir = 2'd0;
        else if (i_down)  want_dir = 2'd2;
        else if (i_left)  want_dir = 2'd3;
        else if (i_right) want_dir = 2'd1;
        else              want_vld = 1'b0;
    end

    // One-tile step in the current facing; edges clamp or wrap.
    always_comb begin
        nx = o_tank_x;
        ny = o_tank_y;
        case (o_tank_dir)
            2'd0: ny = (o_tank_y == 6'd0)  ? (WRAP ? Y_MAX : o_tank_y) : o_tank_y - 6'd1;
            2'd1: nx = (o_tank_x == X_MAX) ? (WRAP ? 6'd0  : o_tank_x) : o_tank_x + 6'd1;
            2'd2: ny = (o_tank_y == Y_MAX) ? (WRAP ? 6'd0  : o_tank_y) : o_tank_y + 6'd1;
            default: nx = (o_tank_x == 6'd0) ? (WRAP ? X_MAX : o_tank_x) : o_tank_x - 6'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcnt       <= '0;
            o_tank_x   <= 6'(INIT_X);
            o_tank_y   <= 6'(INIT_Y);
            o_tank_dir <= 2'(INIT_DIR);
        end else begin
            if (tick_en)
                mcnt <= move_tick ? '0 : mcnt + 1'b1;
            // A differing direction costs a whole move tick to turn in place.
            if (move_tick && want_vld) begin
                if (want_dir != o_tank_dir) begin
                    o_tank_dir <= want_dir;
                end else begin
                    o_tank_x <= nx;
                    o_tank_y <= ny;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        snap_ld   = 1'b0;
        cool_ld   = 1'b0;
        cool_dec  = 1'b0;
        case (state)
            F_IDLE: if (tick_en && i_fire) begin
                state_nxt = F_REQ;
                snap_ld   = 1'b1;
            end
            F_REQ: if (i_fire_ack) begin
                state_nxt = F_COOL;
                cool_ld   = 1'b1;
            end
            F_COOL: if (tick_en) begin
                if (cool_cnt == '0) state_nxt = F_IDLE;
                else                cool_dec  = 1'b1;
            end
            default: state_nxt = F_IDLE;
        endcase
    end

    // Snapshot takes pre-move values since it samples the same edge as the move.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= F_IDLE;
            cool_cnt   <= '0;
            o_fire_x   <= '0;
            o_fire_y   <= '0;
            o_fire_dir <= '0;
        end else begin
            state <= state_nxt;
            if (cool_ld)       cool_cnt <= COOL_INIT;
            else if (cool_dec) cool_cnt <= cool_cnt - 1'b1;
            if (snap_ld) begin
                o_fire_x   <= o_tank_x;
                o_fire_y   <= o_tank_y;
                o_fire_dir <= o_tank_dir;
            end
        end
    end

    assign o_fire_req = (state == F_REQ);
    assign o_cooldown = (state == F_COOL);

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Directed bench for tank_motion_ctrl: movement vector table plus fire/pause/reset sequences.
module tb_tank_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_frame_tick, i_enable;
    logic       i_up, i_down, i_left, i_right, i_fire, i_fire_ack;
    logic [5:0] o_tank_x, o_tank_y, o_fire_x, o_fire_y;
    logic [1:0] o_tank_dir, o_fire_dir;
    logic       o_fire_req, o_cooldown;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tank_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_frame_tick(i_frame_tick), .i_enable(i_enable),
        .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
        .i_fire(i_fire), .i_fire_ack(i_fire_ack),
        .o_tank_x(o_tank_x), .o_tank_y(o_tank_y), .o_tank_dir(o_tank_dir),
        .o_fire_req(o_fire_req), .o_fire_x(o_fire_x), .o_fire_y(o_fire_y),
        .o_fire_dir(o_fire_dir), .o_cooldown(o_cooldown)
    );

    // Buttons packed as {up, down, left, right}.
    typedef struct {
        logic [3:0] btn;
        logic       en;
        int         n;
        int         ex;
        int         ey;
        int         ed;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_pos(input string name, input int x, input int y, input int d);
        chk({name, ".x"}, 32'(o_tank_x), x);
        chk({name, ".y"}, 32'(o_tank_y), y);
        chk({name, ".dir"}, 32'(o_tank_dir), d);
    endtask

    // Buttons read 1111 between ticks: only the tick-cycle level may matter.
    task automatic tick(input logic [3:0] b, input logic f, input logic en);
        @(negedge clk);
        {i_up, i_down, i_left, i_right} = b;
        i_fire = f;
        i_enable = en;
        i_frame_tick = 1'b1;
        @(negedge clk);
        i_frame_tick = 1'b0;
        {i_up, i_down, i_left, i_right} = 4'b1111;
        @(negedge clk);
    endtask

    task automatic go(input logic [3:0] b, input int n);
        repeat (n) tick(b, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl[13];
    int   wx0, wx1, wy;

    initial begin
        rst_n = 1'b0; i_frame_tick = 0; i_enable = 1; i_fire = 0; i_fire_ack = 0;
        {i_up, i_down, i_left, i_right} = 4'b0000;

        tbl[0]  = '{4'b0001, 1'b1, 4, 32, 2, 1};
        tbl[1]  = '{4'b0001, 1'b1, 4, 33, 2, 1};
        tbl[2]  = '{4'b0001, 1'b1, 4, 34, 2, 1};
        tbl[3]  = '{4'b0000, 1'b1, 4, 34, 2, 1};
        tbl[4]  = '{4'b1010, 1'b1, 4, 34, 2, 0};
        tbl[5]  = '{4'b1000, 1'b1, 4, 34, 1, 0};
        tbl[6]  = '{4'b0101, 1'b1, 3, 34, 1, 0};
        tbl[7]  = '{4'b0101, 1'b1, 1, 34, 1, 2};
        tbl[8]  = '{4'b0100, 1'b0, 4, 34, 1, 2};
        tbl[9]  = '{4'b0100, 1'b1, 4, 34, 2, 2};
        tbl[10] = '{4'b0010, 1'b1, 4, 34, 2, 3};
        tbl[11] = '{4'b0010, 1'b1, 4, 33, 2, 3};
        tbl[12] = '{4'b0111, 1'b1, 4, 33, 2, 2};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_pos("reset", 32, 2, 0);
        chk("reset.req", 32'(o_fire_req), 0);
        chk("reset.cool", 32'(o_cooldown), 0);
        chk("reset.snap", {20'd0, o_fire_x, o_fire_y, o_fire_dir}, 0);

        // Ack outside F_REQ must be ignored.
        @(negedge clk); i_fire_ack = 1'b1;
        @(negedge clk); i_fire_ack = 1'b0;
        chk("idle_ack.cool", 32'(o_cooldown), 0);

        for (int i = 0; i < 13; i++) begin
            repeat (tbl[i].n) tick(tbl[i].btn, 1'b0, tbl[i].en);
            chk_pos($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ed);
            chk($sformatf("vec%0d.req", i), 32'(o_fire_req), 0);
        end

        // Right edge and top edge.
`ifdef TANK_WRAP_EN
        wx0 = 0; wx1 = 1; wy = 29;
`else
        wx0 = 39; wx1 = 39; wy = 0;
`endif
        do_reset();
        go(4'b0001, 4);
        go(4'b0001, 28);
        chk_pos("edge.x39", 39, 2, 1);
        go(4'b0001, 4);
        chk_pos("edge.r1", wx0, 2, 1);
        go(4'b0001, 4);
        chk_pos("edge.r2", wx1, 2, 1);
        go(4'b1000, 12);
        chk_pos("edge.y0", wx1, 0, 0);
        go(4'b1000, 4);
        chk_pos("edge.up", wx1, wy, 0);

        // Walk to (10,5) facing down; 108 ticks leaves mcnt at 0.
        do_reset();
        go(4'b0010, 4);
        go(4'b0010, 88);
        go(4'b0100, 4);
        go(4'b0100, 12);
        chk_pos("walk", 10, 5, 2);
        go(4'b0000, 3);
        tick(4'b0100, 1'b1, 1'b1);
        chk_pos("fire.move", 10, 6, 2);
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("wait%0d.req", c), 32'(o_fire_req), 1);
            chk($sformatf("wait%0d.snap", c), {20'd0, o_fire_x, o_fire_y, o_fire_dir},
                {20'd0, 6'd10, 6'd5, 2'd2});
            @(negedge clk);
        end
        i_fire_ack = 1'b1;
        @(negedge clk);
        i_fire_ack = 1'b0;
        chk("ack.req", 32'(o_fire_req), 0);
        chk("ack.cool", 32'(o_cooldown), 1);
        for (int t = 1; t <= 16; t++) begin
            tick(4'b0000, 1'b1, 1'b1);
            chk($sformatf("cool_t%0d.cool", t), 32'(o_cooldown), (t <= 14) ? 1 : 0);
            chk($sformatf("cool_t%0d.req", t), 32'(o_fire_req), (t == 16) ? 1 : 0);
        end
        chk("refire.snap", {20'd0, o_fire_x, o_fire_y, o_fire_dir},
            {20'd0, 6'd10, 6'd6, 2'd2});

        // Pause while a request is pending.
        @(negedge clk);
        i_enable = 1'b0;
        i_fire_ack = 1'b1;
        @(negedge clk);
        i_fire_ack = 1'b0;
        chk("pause_ack.req", 32'(o_fire_req), 0);
        chk("pause_ack.cool", 32'(o_cooldown), 1);
        for (int t = 0; t < 20; t++) begin
            tick(4'b0100, 1'b1, 1'b0);
            chk($sformatf("pause%0d.cool", t), 32'(o_cooldown), 1);
        end
        chk_pos("pause.pos", 10, 6, 2);
        for (int t = 1; t <= 16; t++) begin
            tick(4'b0000, 1'b1, 1'b1);
            chk($sformatf("resume_t%0d.cool", t), 32'(o_cooldown), (t <= 14) ? 1 : 0);
            chk($sformatf("resume_t%0d.req", t), 32'(o_fire_req), (t == 16) ? 1 : 0);
        end

        // Reset with the handshake outstanding.
        do_reset();
        chk_pos("midreset", 32, 2, 0);
        chk("midreset.req", 32'(o_fire_req), 0);
        chk("midreset.cool", 32'(o_cooldown), 0);
        chk("midreset.snap", {20'd0, o_fire_x, o_fire_y, o_fire_dir}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tank_motion_ctrl.md
Name: tank_motion_ctrl

Overview:
- Per-player tank controller between a debounced joystick and the VGA renderer.
- Turns direction buttons into grid moves on the 40x30 tile map (16x16-pixel tiles, 640x480), paced by the frame tick.
- Drives the tank x/y/direction inputs of the renderer.
- Schedules fire requests to the bullet engine via a req/ack handshake with cooldown.

Parameters:
- MAP_W, 40, map width in tiles; legal x = 0..MAP_W-1
- MAP_H, 30, map height in tiles; legal y = 0..MAP_H-1
- INIT_X, 32, x tile after reset
- INIT_Y, 2, y tile after reset
- INIT_DIR, 0, direction after reset (0 up, 1 right, 2 down, 3 left)
- MOVE_PERIOD, 4, frame ticks per movement decision (>=1)
- FIRE_COOLDOWN, 15, frame ticks after an ack before the next fire is allowed (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
- i_enable  in  1  1 = game running; 0 = paused
- i_up, i_down, i_left, i_right  in  1 each  debounced buttons, active-high
- i_fire  in  1  debounced fire button, active-high
- i_fire_ack  in  1  bullet engine accepts the current request
- o_tank_x  out  6  current x tile
- o_tank_y  out  6  current y tile
- o_tank_dir  out  2  current facing
- o_fire_req  out  1  fire request, level, held until acked
- o_fire_x, o_fire_y  out  6 each  muzzle tile snapshot, valid while o_fire_req=1
- o_fire_dir  out  2  direction snapshot, valid while o_fire_req=1
- o_cooldown  out  1  1 while the fire FSM is in F_COOL

Behaviour:
- Interface: one clock; reset is synchronous and active-low, ports named clk and rst_n.
- Reset (rst_n=0 at a clk edge):
  - o_tank_x=INIT_X, o_tank_y=INIT_Y, o_tank_dir=INIT_DIR.
  - o_fire_req=0, o_fire_x/y/dir=0, o_cooldown=0.
  - Frame counter=0; fire FSM=F_IDLE.
  - Reset mid-handshake drops o_fire_req at that same edge.
- Frame counter mcnt (width clog2(MOVE_PERIOD), min 1):
  - Increments on each i_frame_tick while i_enable=1.
  - A tick arriving with mcnt==MOVE_PERIOD-1 is a move tick; mcnt wraps to 0 on that tick.
- Move decision, evaluated at a move tick:
  - Priority up > down > left > right; the highest pressed button sets the wanted direction D.
  - No button pressed: no change.
  - D != o_tank_dir: o_tank_dir<=D; position unchanged (turn-in-place costs one move tick).
  - D == o_tank_dir: step one tile toward D. Up is y-1, down y+1, left x-1, right x+1.
  - At a boundary (x=0 going left, x=MAP_W-1 going right, y=0 going up, y=MAP_H-1 going down): clamp, position unchanged.
  - Outputs update on the clk edge that samples the tick (latency 1 cycle from tick to new value).
- Fire FSM, states F_IDLE, F_REQ, F_COOL:
  - F_IDLE -> F_REQ: at any i_frame_tick with i_enable=1 and i_fire=1. On that edge set o_fire_req=1 and snapshot o_fire_x/y/dir from the pre-move position and direction.
  - Move and fire in the same tick: the snapshot uses the old values.
  - F_REQ: o_fire_req held at 1 and snapshot stable until a clk edge with i_fire_ack=1.
  - On that edge: o_fire_req<=0, cooldown counter<=FIRE_COOLDOWN-1, go to F_COOL.
  - i_fire_ack while in F_IDLE or F_COOL is ignored.
  - F_COOL: o_cooldown=1. Each enabled i_frame_tick decrements the counter. A tick at 0 goes to F_IDLE; o_cooldown=0 after that edge.
  - Holding i_fire continuously therefore fires once per FIRE_COOLDOWN+1 ticks at most (plus ack wait).
- Pause (i_enable=0):
  - Ticks are ignored: no moves, mcnt and cooldown frozen, no new requests.
  - A pending F_REQ stays asserted and can still be acked; the ack moves the FSM to F_COOL, which stays frozen until i_enable=1.
- Button changes between ticks have no effect; only levels at the tick cycle matter.

Optional Feature:
- Macro TANK_WRAP_EN.
- Defined: boundary steps wrap around instead of clamping: x 0 left -> MAP_W-1, x MAP_W-1 right -> 0; same for y with MAP_H.
- Undefined: clamp as in Behaviour. All other behaviour is identical.

Test Plan:
- Reset with defaults; assert rst_n=0 for one edge mid-run -> x=32, y=2, dir=0, o_fire_req=0 on the next cycle.
- dir=0, hold i_right, 4 ticks (MOVE_PERIOD=4) -> after 4th tick dir=1, x=32. After 4 more ticks x=33. After 4 more ticks x=34.
- Start x=39, dir=1, hold i_right for 8 ticks -> x stays 39. With TANK_WRAP_EN: x=0 after the first move tick, then 1.
- Press i_up+i_left together at a move tick with dir=3 -> dir becomes 0 (up wins), position unchanged.
- Hold i_fire at tick with x=10, y=5, dir=2; delay ack 7 cycles -> o_fire_req=1 and snapshot (10,5,2) stable for 7 cycles. o_fire_req=0 on the edge after ack; o_cooldown=1 for exactly 15 ticks; next request on the 16th tick.
- i_fire held, i_enable=0 while o_fire_req=1 -> ack accepted, o_cooldown stays 1 with counter frozen across 20 ticks. Resumes counting after i_enable=1; no moves while paused.
